// File: rtl/seg_display_pkg.sv
// Shared types and constants for the UART 7-segment display scheduler.
// Holds the FSM state encoding, blank codes and the digit-index-to-source map.
package seg_display_pkg;

   typedef enum logic {
      S_DRIVE = 1'b0,
      S_BLANK = 1'b1
   } state_e;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [3:0] AN_OFF    = 4'b1111;

   // Digit index -> nibble source
   localparam logic [1:0] IDX_RX_LO = 2'd0;
   localparam logic [1:0] IDX_RX_HI = 2'd1;
   localparam logic [1:0] IDX_TX_LO = 2'd2;
   localparam logic [1:0] IDX_TX_HI = 2'd3;

   // Active-low one-hot anode pattern for a digit index
   function automatic logic [3:0] an_onehot(input logic [1:0] idx);
      return ~(4'b0001 << idx);
   endfunction

endpackage

// File: rtl/HexTo7Segment.sv
// Combinational hex nibble to active-low 7-segment (gfedcba) decoder.
// Ports: i_hex [3:0] nibble in; o_seg [6:0] cathode pattern out, active-low.
module HexTo7Segment (
   input  logic [3:0] i_hex,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = 7'h7F;
      unique case (i_hex)
         4'h0: o_seg = 7'h40;
         4'h1: o_seg = 7'h79;
         4'h2: o_seg = 7'h24;
         4'h3: o_seg = 7'h30;
         4'h4: o_seg = 7'h19;
         4'h5: o_seg = 7'h12;
         4'h6: o_seg = 7'h02;
         4'h7: o_seg = 7'h78;
         4'h8: o_seg = 7'h00;
         4'h9: o_seg = 7'h10;
         4'hA: o_seg = 7'h08;
         4'hB: o_seg = 7'h03;
         4'hC: o_seg = 7'h46;
         4'hD: o_seg = 7'h21;
         4'hE: o_seg = 7'h06;
         4'hF: o_seg = 7'h0E;
      endcase
   end

endmodule

// File: rtl/seg_display_scheduler.sv
// Time-multiplexes the last RX byte (AN1:AN0) and last TX byte (AN3:AN2) onto a
// 4-digit 7-segment display, with a blank gap after every digit slot.
// Ports: clk, rst (sync, active-high); rx_valid/rx_data, tx_valid/tx_data byte
// capture; seg[6:0] cathodes and an[3:0] anodes (registered, active-low);
// frame_tick pulses on the frame commit cycle.
module seg_display_scheduler
   import seg_display_pkg::*;
#(
   parameter int DIGIT_TICKS = 100000,
   parameter int BLANK_TICKS = 1000,
   parameter int CNT_W       = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic [6:0] seg,
   output logic [3:0] an,
   output logic       frame_tick
);

   localparam logic [CNT_W-1:0] DRV_LAST = CNT_W'(DIGIT_TICKS - 1);
   localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLANK_TICKS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_e           r_state;
   state_e           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [1:0]       r_idx;
   logic [1:0]       w_idx_nxt;
   logic             w_commit;

   logic [7:0]       r_rx_shadow;
   logic             r_rx_pend;
   logic [7:0]       r_rx_disp;
   logic             r_rx_loaded;
   logic [7:0]       r_tx_shadow;
   logic             r_tx_pend;
   logic [7:0]       r_tx_disp;
   logic             r_tx_loaded;

   logic [3:0]       w_nib;
   logic             w_loaded;
   logic [6:0]       w_hex_seg;
   logic [6:0]       r_seg;
   logic [3:0]       r_an;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_DRIVE;
         r_cnt   <= '0;
         r_idx   <= 2'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + CNT_ONE;
      w_idx_nxt   = r_idx;
      w_commit    = 1'b0;
      unique case (r_state)
         S_DRIVE: begin
            if (r_cnt == DRV_LAST) begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_BLANK;
            end
         end
         S_BLANK: begin
            if (r_cnt == BLK_LAST) begin
               w_cnt_nxt   = '0;
               w_idx_nxt   = r_idx + 2'd1;
               w_state_nxt = S_DRIVE;
               // End of the last blank closes the frame
               w_commit    = (r_idx == IDX_TX_HI);
            end
         end
         default: begin
            w_state_nxt = S_DRIVE;
         end
      endcase
   end

   assign frame_tick = w_commit;

   // Capture always lands in the shadow; a valid in the commit cycle keeps
   // pend set while the display takes the pre-update shadow value.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_shadow <= 8'h00;
         r_rx_pend   <= 1'b0;
         r_rx_disp   <= 8'h00;
         r_rx_loaded <= 1'b0;
      end else begin
         if (w_commit && r_rx_pend) begin
            r_rx_disp   <= r_rx_shadow;
            r_rx_loaded <= 1'b1;
         end
         if (rx_valid) begin
            r_rx_shadow <= rx_data;
            r_rx_pend   <= 1'b1;
         end else if (w_commit) begin
            r_rx_pend   <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_shadow <= 8'h00;
         r_tx_pend   <= 1'b0;
         r_tx_disp   <= 8'h00;
         r_tx_loaded <= 1'b0;
      end else begin
         if (w_commit && r_tx_pend) begin
            r_tx_disp   <= r_tx_shadow;
            r_tx_loaded <= 1'b1;
         end
         if (tx_valid) begin
            r_tx_shadow <= tx_data;
            r_tx_pend   <= 1'b1;
         end else if (w_commit) begin
            r_tx_pend   <= 1'b0;
         end
      end
   end

   always_comb begin
      w_nib    = 4'h0;
      w_loaded = 1'b0;
      unique case (r_idx)
         IDX_RX_LO: begin
            w_nib    = r_rx_disp[3:0];
            w_loaded = r_rx_loaded;
         end
         IDX_RX_HI: begin
            w_nib    = r_rx_disp[7:4];
            w_loaded = r_rx_loaded;
         end
         IDX_TX_LO: begin
            w_nib    = r_tx_disp[3:0];
            w_loaded = r_tx_loaded;
         end
         IDX_TX_HI: begin
            w_nib    = r_tx_disp[7:4];
            w_loaded = r_tx_loaded;
         end
      endcase
   end

   HexTo7Segment u_hex (
      .i_hex (w_nib),
      .o_seg (w_hex_seg)
   );

   // An unloaded source still consumes its slot but stays dark
   always_ff @(posedge clk) begin
      if (rst) begin
         r_an  <= AN_OFF;
         r_seg <= SEG_BLANK;
      end else if (r_state == S_DRIVE && w_loaded) begin
         r_an  <= an_onehot(r_idx);
         r_seg <= w_hex_seg;
      end else begin
         r_an  <= AN_OFF;
         r_seg <= SEG_BLANK;
      end
   end

   assign an  = r_an;
   assign seg = r_seg;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Self-checking bench for seg_display_scheduler (DIGIT_TICKS=4, BLANK_TICKS=2).
// Table vectors, hand sequences and a random run against a frame-arithmetic model.
module tb_seg_display_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic [6:0] seg;
   logic [3:0] an;
   logic       frame_tick;

   int total = 0;
   int bad   = 0;

   seg_display_scheduler #(
      .DIGIT_TICKS (4),
      .BLANK_TICKS (2),
      .CNT_W       (20)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .tx_valid   (tx_valid),
      .tx_data    (tx_data),
      .seg        (seg),
      .an         (an),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   // Active-high gfedcba patterns; the display is driven with their inverse
   localparam logic [6:0] HI [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   function automatic logic [6:0] dec(input logic [3:0] n);
      return ~HI[n];
   endfunction

   // Model: k = cycles since reset; slot = k/6 mod 4; drive while k%6 < 4;
   // frame commit at k%24 == 23. Index 0 = RX, 1 = TX.
   int         m_k = 0;
   bit         m_valid = 0;
   logic [7:0] m_sh [2];
   logic [7:0] m_dp [2];
   bit         m_pend [2];
   bit         m_ld [2];
   logic [3:0] m_an;
   logic [6:0] m_seg;

   bit track = 0;
   int lo_run = 0;
   int hi_run = 0;
   bit seen_pulse = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (k=%0d)", name, act, exp, m_k);
      end
   endtask

   task automatic cyc(input bit r, input bit rv, input logic [7:0] rd,
                      input bit tv, input logic [7:0] td);
      int slot;
      int src;
      logic [3:0] nib;
      rst = r;
      rx_valid = rv;
      rx_data = rd;
      tx_valid = tv;
      tx_data = td;
      if (m_valid)
         check("frame_tick", frame_tick, ((m_k % 24) == 23) ? 1 : 0);
      @(posedge clk);
      if (r) begin
         m_k = 0;
         m_valid = 1;
         for (int s = 0; s < 2; s++) begin
            m_sh[s] = 8'h00;
            m_dp[s] = 8'h00;
            m_pend[s] = 0;
            m_ld[s] = 0;
         end
         m_an = 4'hF;
         m_seg = 7'h7F;
      end else begin
         slot = (m_k / 6) % 4;
         src = slot / 2;
         nib = (slot % 2 == 1) ? m_dp[src][7:4] : m_dp[src][3:0];
         if ((m_k % 6) < 4 && m_ld[src]) begin
            m_an = ~(4'b0001 << slot);
            m_seg = dec(nib);
         end else begin
            m_an = 4'hF;
            m_seg = 7'h7F;
         end
         if ((m_k % 24) == 23) begin
            for (int s = 0; s < 2; s++) begin
               if (m_pend[s]) begin
                  m_dp[s] = m_sh[s];
                  m_ld[s] = 1;
                  m_pend[s] = 0;
               end
            end
         end
         if (rv) begin
            m_sh[0] = rd;
            m_pend[0] = 1;
         end
         if (tv) begin
            m_sh[1] = td;
            m_pend[1] = 1;
         end
         m_k++;
      end
      #1;
      check("an", an, m_an);
      check("seg", seg, m_seg);
      check("an_onehot", ($countones(~an) <= 1) ? 1 : 0, 1);
      check("lit_blank", (an != 4'hF && seg == 7'h7F) ? 1 : 0, 0);
      if (track) begin
         if (an != 4'hF) begin
            if (lo_run == 0 && seen_pulse)
               check("blank_len", hi_run, 2);
            lo_run++;
            hi_run = 0;
         end else begin
            if (lo_run > 0) begin
               check("pulse_len", lo_run, 4);
               seen_pulse = 1;
            end
            lo_run = 0;
            hi_run++;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(0, 0, 8'h00, 0, 8'h00);
   endtask

   task automatic run_to(input int k);
      int guard = 0;
      while (m_k != k && guard < 400) begin
         cyc(0, 0, 8'h00, 0, 8'h00);
         guard++;
      end
      if (m_k != k) begin
         bad++;
         total++;
         $display("FAIL run_to: k=%0d want %0d", m_k, k);
      end
   endtask

   typedef struct packed {
      bit              p_rv;
      logic [7:0]      p_rd;
      bit              rv;
      logic [7:0]      rd;
      bit              tv;
      logic [7:0]      td;
      logic [3:0][3:0] an;
      logic [3:0][6:0] sg;
   } vec_t;

   vec_t vecs [4];

   initial begin
      vecs[0] = '{0, 8'h00, 0, 8'h00, 0, 8'h00,
                  {4'hF, 4'hF, 4'hF, 4'hF},
                  {7'h7F, 7'h7F, 7'h7F, 7'h7F}};
      vecs[1] = '{0, 8'h00, 1, 8'hA5, 0, 8'h00,
                  {4'hF, 4'hF, 4'hD, 4'hE},
                  {7'h7F, 7'h7F, 7'h08, 7'h12}};
      vecs[2] = '{1, 8'h12, 1, 8'h34, 1, 8'hC3,
                  {4'h7, 4'hB, 4'hD, 4'hE},
                  {7'h46, 7'h30, 7'h30, 7'h19}};
      vecs[3] = '{0, 8'h00, 0, 8'h00, 1, 8'h0F,
                  {4'h7, 4'hB, 4'hF, 4'hF},
                  {7'h40, 7'h0E, 7'h7F, 7'h7F}};

      // Reset state
      cyc(1, 0, 8'h00, 0, 8'h00);
      check("rst_an", an, 4'hF);
      check("rst_seg", seg, 7'h7F);
      check("rst_tick", frame_tick, 0);
      // Idle display stays dark for 3 frames
      run_to(72);
      check("idle_an", an, 4'hF);

      // Table vectors: apply in frame 0, sample frame 2 slots
      for (int v = 0; v < 4; v++) begin
         cyc(1, 0, 8'h00, 0, 8'h00);
         idle(2);
         if (vecs[v].p_rv) cyc(0, 1, vecs[v].p_rd, 0, 8'h00);
         idle(3);
         cyc(0, vecs[v].rv, vecs[v].rd, vecs[v].tv, vecs[v].td);
         for (int d = 0; d < 4; d++) begin
            run_to(48 + 6 * d + 2);
            check($sformatf("vec%0d_an%0d", v, d), an, vecs[v].an[d]);
            check($sformatf("vec%0d_seg%0d", v, d), seg, vecs[v].sg[d]);
         end
      end

      // Valid exactly on the commit cycle
      cyc(1, 0, 8'h00, 0, 8'h00);
      idle(3);
      cyc(0, 1, 8'h11, 0, 8'h00);
      run_to(23);
      check("commit_tick", frame_tick, 1);
      cyc(0, 1, 8'h7E, 0, 8'h00);
      run_to(26);
      check("old_rx_lo", seg, 7'h79);
      run_to(32);
      check("old_rx_hi", seg, 7'h79);
      run_to(50);
      check("new_rx_lo", seg, 7'h06);
      check("new_rx_an", an, 4'hE);
      run_to(56);
      check("new_rx_hi", seg, 7'h78);

      // Reset during an idx2 drive slot with TX pending
      cyc(1, 0, 8'h00, 0, 8'h00);
      idle(2);
      cyc(0, 1, 8'h21, 1, 8'h43);
      run_to(26);
      cyc(0, 0, 8'h00, 1, 8'h99);
      run_to(38);
      check("pre_rst_an", an, 4'hB);
      check("pre_rst_seg", seg, 7'h30);
      cyc(1, 0, 8'h00, 0, 8'h00);
      check("mid_rst_an", an, 4'hF);
      check("mid_rst_seg", seg, 7'h7F);
      run_to(62);
      check("post_rst_tx", an, 4'hF);
      run_to(68);
      check("post_rst_tx_hi", an, 4'hF);

      // Random valids against the model, with pulse/blank width tracking
      cyc(1, 0, 8'h00, 0, 8'h00);
      cyc(0, 1, 8'($urandom), 1, 8'($urandom));
      lo_run = 0;
      hi_run = 0;
      seen_pulse = 0;
      track = 1;
      repeat (800) begin
         cyc(0, $urandom_range(0, 7) == 0, 8'($urandom),
             $urandom_range(0, 9) == 0, 8'($urandom));
      end
      track = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
